// File: rtl/csr_excp_badv.sv
// Exception capture (ERA/ESTAT/BADV), EENTRY, timed flush/redirect and CSR access.
// Optional fault counter at CSR 0x0F0 when CSR_EXCP_CNT_EN is defined.
module csr_excp_badv #(
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [31:0] EENTRY_RST   = 32'h1c000000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid_w,
   input  logic [31:0] pc_w,
   input  logic        excp_adef_w,
   input  logic        excp_ine_w,
   input  logic        excp_sys_w,
   input  logic        excp_brk_w,
   input  logic        excp_ale_w,
   input  logic [31:0] vaddr_w,
   input  logic        ertn_w,
   input  logic [13:0] csr_num,
   input  logic        csr_we,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        excp_flush,
   output logic [31:0] excp_target
);

   localparam logic [13:0] CSR_ESTAT  = 14'h005;
   localparam logic [13:0] CSR_ERA    = 14'h006;
   localparam logic [13:0] CSR_BADV   = 14'h007;
   localparam logic [13:0] CSR_EENTRY = 14'h00c;
   localparam logic [13:0] CSR_CNT    = 14'h0f0;

   localparam logic [5:0] EC_ADEF = 6'h08;
   localparam logic [5:0] EC_INE  = 6'h0d;
   localparam logic [5:0] EC_SYS  = 6'h0b;
   localparam logic [5:0] EC_BRK  = 6'h0c;
   localparam logic [5:0] EC_ALE  = 6'h09;

   localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

   typedef enum logic {
      S_IDLE,
      S_FLUSH
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_fcnt;
   logic [2:0]  w_fcnt_nxt;

   logic [31:0] r_era;
   logic [31:0] r_badv;
   logic [25:0] r_eentry;
   logic [1:0]  r_is;
   logic [5:0]  r_ecode;
   logic [8:0]  r_esub;
   logic [31:0] r_target;

   logic        w_idle;
   logic        w_fault;
   logic        w_take_fault;
   logic        w_take_ertn;
   logic        w_csr_wr;
   logic [5:0]  w_ecode;
   logic [31:0] w_era_wr;
   logic [31:0] w_badv_wr;
   logic [31:0] w_eentry_wr;
   logic [31:0] w_estat_wr;

   function automatic logic [31:0] f_merge(
      input logic [31:0] cur,
      input logic [31:0] mask,
      input logic [31:0] data
   );
      return (cur & ~mask) | (data & mask);
   endfunction

   assign w_idle  = (r_state == S_IDLE);
   assign w_fault = valid_w & (excp_adef_w | excp_ine_w | excp_sys_w |
                               excp_brk_w | excp_ale_w);

   // Anything arriving while flushing belongs to a squashed instruction.
   assign w_take_fault = w_idle & w_fault;
   assign w_take_ertn  = w_idle & valid_w & ertn_w & ~w_fault;
   assign w_csr_wr     = w_idle & valid_w & csr_we & ~w_fault;

   always_comb begin
      w_ecode = EC_ALE;
      if (excp_adef_w)      w_ecode = EC_ADEF;
      else if (excp_ine_w)  w_ecode = EC_INE;
      else if (excp_sys_w)  w_ecode = EC_SYS;
      else if (excp_brk_w)  w_ecode = EC_BRK;
   end

   assign w_era_wr    = f_merge(r_era, csr_wmask, csr_wdata);
   assign w_badv_wr   = f_merge(r_badv, csr_wmask, csr_wdata);
   assign w_eentry_wr = f_merge({r_eentry, 6'b0}, csr_wmask, csr_wdata);
   assign w_estat_wr  = f_merge({30'b0, r_is}, csr_wmask, csr_wdata);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      excp_flush  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_take_fault | w_take_ertn) begin
               w_state_nxt = S_FLUSH;
               w_fcnt_nxt  = CNT_INIT;
            end
         end
         S_FLUSH: begin
            excp_flush = 1'b1;
            if (r_fcnt == 3'd0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_fcnt_nxt = r_fcnt - 3'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_fcnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_era <= '0;
      end else if (w_take_fault) begin
         r_era <= pc_w;
      end else if (w_csr_wr && csr_num == CSR_ERA) begin
         r_era <= w_era_wr;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_badv <= '0;
      end else if (w_take_fault) begin
         if (w_ecode == EC_ADEF) begin
            r_badv <= pc_w;
         end else if (w_ecode == EC_ALE) begin
            r_badv <= vaddr_w;
         end
      end else if (w_csr_wr && csr_num == CSR_BADV) begin
         r_badv <= w_badv_wr;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_eentry <= EENTRY_RST[31:6];
      end else if (w_csr_wr && csr_num == CSR_EENTRY) begin
         r_eentry <= w_eentry_wr[31:6];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_is    <= '0;
         r_ecode <= '0;
         r_esub  <= '0;
      end else if (w_take_fault) begin
         r_ecode <= w_ecode;
         r_esub  <= '0;
      end else if (w_csr_wr && csr_num == CSR_ESTAT) begin
         r_is <= w_estat_wr[1:0];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_target <= '0;
      end else if (w_take_fault) begin
         r_target <= {r_eentry, 6'b0};
      end else if (w_take_ertn) begin
         r_target <= r_era;
      end
   end

   assign excp_target = r_target;

`ifdef CSR_EXCP_CNT_EN
   logic [31:0] r_fault_cnt;
   logic [31:0] w_cnt_wr;

   assign w_cnt_wr = f_merge(r_fault_cnt, csr_wmask, csr_wdata);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fault_cnt <= '0;
      end else if (w_take_fault) begin
         r_fault_cnt <= r_fault_cnt + 32'd1;
      end else if (w_csr_wr && csr_num == CSR_CNT) begin
         r_fault_cnt <= w_cnt_wr;
      end
   end
`endif

   always_comb begin
      csr_rdata = '0;
      case (csr_num)
         CSR_ESTAT:  csr_rdata = {1'b0, r_esub, r_ecode, 14'b0, r_is};
         CSR_ERA:    csr_rdata = r_era;
         CSR_BADV:   csr_rdata = r_badv;
         CSR_EENTRY: csr_rdata = {r_eentry, 6'b0};
`ifdef CSR_EXCP_CNT_EN
         CSR_CNT:    csr_rdata = r_fault_cnt;
`else
         CSR_CNT:    csr_rdata = '0;
`endif
         default:    csr_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_csr_excp_badv.sv
// Self-checking bench for csr_excp_badv: directed vector table,
// multi-cycle corner sequences and randomized run against a reference model.
module tb_csr_excp_badv;

   logic        clk = 1'b0;
   logic        resetn;
   logic        valid_w;
   logic [31:0] pc_w;
   logic        excp_adef_w;
   logic        excp_ine_w;
   logic        excp_sys_w;
   logic        excp_brk_w;
   logic        excp_ale_w;
   logic [31:0] vaddr_w;
   logic        ertn_w;
   logic [13:0] csr_num;
   logic        csr_we;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        excp_flush;
   logic [31:0] excp_target;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   csr_excp_badv dut (
      .clk         (clk),
      .resetn      (resetn),
      .valid_w     (valid_w),
      .pc_w        (pc_w),
      .excp_adef_w (excp_adef_w),
      .excp_ine_w  (excp_ine_w),
      .excp_sys_w  (excp_sys_w),
      .excp_brk_w  (excp_brk_w),
      .excp_ale_w  (excp_ale_w),
      .vaddr_w     (vaddr_w),
      .ertn_w      (ertn_w),
      .csr_num     (csr_num),
      .csr_we      (csr_we),
      .csr_wmask   (csr_wmask),
      .csr_wdata   (csr_wdata),
      .csr_rdata   (csr_rdata),
      .excp_flush  (excp_flush),
      .excp_target (excp_target)
   );

   // f = {adef, ine, sys, brk, ale}
   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [4:0]  f;
      logic [31:0] va;
      logic        ertn;
      logic [13:0] num;
      logic        we;
      logic [31:0] mask;
      logic [31:0] wd;
      logic [13:0] chk;
      logic        e_fl;
      logic [31:0] e_tgt;
      logic [31:0] e_rd;
   } vec_t;

   localparam logic [4:0] F_ADEF = 5'b10000;
   localparam logic [4:0] F_INE  = 5'b01000;
   localparam logic [4:0] F_SYS  = 5'b00100;
   localparam logic [4:0] F_BRK  = 5'b00010;
   localparam logic [4:0] F_ALE  = 5'b00001;
   localparam int         FLUSH_N = 2;

   // reference model state
   logic [31:0] m_era, m_badv, m_eentry, m_cnt, m_tgt;
   logic [1:0]  m_is;
   logic [5:0]  m_ec;
   int          m_fl;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic v, input logic [31:0] pc, input logic [4:0] f,
      input logic [31:0] va, input logic ertn, input logic [13:0] num,
      input logic we, input logic [31:0] mask, input logic [31:0] wd,
      input logic [13:0] c, input logic efl, input logic [31:0] etg,
      input logic [31:0] erd);
      vec_t x;
      x.v = v; x.pc = pc; x.f = f; x.va = va; x.ertn = ertn;
      x.num = num; x.we = we; x.mask = mask; x.wd = wd; x.chk = c;
      x.e_fl = efl; x.e_tgt = etg; x.e_rd = erd;
      return x;
   endfunction

   function automatic vec_t idl(input logic [13:0] c, input logic efl,
                                input logic [31:0] etg, input logic [31:0] erd);
      return mk(0, 0, 0, 0, 0, c, 0, 0, 0, c, efl, etg, erd);
   endfunction

   task automatic drive(input vec_t x);
      valid_w     = x.v;
      pc_w        = x.pc;
      {excp_adef_w, excp_ine_w, excp_sys_w, excp_brk_w, excp_ale_w} = x.f;
      vaddr_w     = x.va;
      ertn_w      = x.ertn;
      csr_num     = x.num;
      csr_we      = x.we;
      csr_wmask   = x.mask;
      csr_wdata   = x.wd;
   endtask

   task automatic quiet(input logic [13:0] n);
      drive(mk(0, 0, 0, 0, 0, n, 0, 0, 0, n, 0, 0, 0));
   endtask

   task automatic cyc(input vec_t x);
      @(negedge clk);
      drive(x);
      @(posedge clk);
      #2;
      quiet(x.chk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      quiet(14'h0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   function automatic void m_reset();
      m_era = 0; m_badv = 0; m_eentry = 32'h1c000000; m_cnt = 0;
      m_tgt = 0; m_is = 0; m_ec = 0; m_fl = 0;
   endfunction

   function automatic logic [31:0] m_rd(input logic [13:0] n);
      case (n)
         14'h005: return {10'b0, m_ec, 14'b0, m_is};
         14'h006: return m_era;
         14'h007: return m_badv;
         14'h00c: return m_eentry & 32'hffffffc0;
`ifdef CSR_EXCP_CNT_EN
         14'h0f0: return m_cnt;
`endif
         default: return 32'h0;
      endcase
   endfunction

   function automatic void m_step(input vec_t x);
      logic [5:0] codes [5];
      logic [31:0] wm;
      codes = '{6'h08, 6'h0d, 6'h0b, 6'h0c, 6'h09};
      if (m_fl > 0) begin
         m_fl--;
      end else if (x.v && x.f != 0) begin
         for (int i = 0; i < 5; i++) begin
            if (x.f[4-i]) begin
               m_ec = codes[i];
               break;
            end
         end
         m_era = x.pc;
         if (x.f[4]) m_badv = x.pc;
         else if (x.f == F_ALE) m_badv = x.va;
         m_tgt = m_eentry & 32'hffffffc0;
         m_fl = FLUSH_N;
         m_cnt = m_cnt + 1;
      end else if (x.v) begin
         if (x.ertn) begin
            m_tgt = m_era;
            m_fl = FLUSH_N;
         end
         if (x.we) begin
            case (x.num)
               14'h006: m_era = (m_era & ~x.mask) | (x.wd & x.mask);
               14'h007: m_badv = (m_badv & ~x.mask) | (x.wd & x.mask);
               14'h00c: begin
                  wm = x.mask & 32'hffffffc0;
                  m_eentry = (m_eentry & ~wm) | (x.wd & wm);
               end
               14'h005: m_is = (m_is & ~x.mask[1:0]) | (x.wd[1:0] & x.mask[1:0]);
`ifdef CSR_EXCP_CNT_EN
               14'h0f0: m_cnt = (m_cnt & ~x.mask) | (x.wd & x.mask);
`endif
               default: ;
            endcase
         end
      end
   endfunction

   localparam int NV = 27;
   vec_t tv [NV];
   logic [31:0] cnt_exp;
   logic [13:0] nums [6];

   initial begin
      nums = '{14'h005, 14'h006, 14'h007, 14'h00c, 14'h0f0, 14'h100};
`ifdef CSR_EXCP_CNT_EN
      cnt_exp = 32'h1234;
`else
      cnt_exp = 32'h0;
`endif
      tv[0]  = mk(1, 32'h1c000010, F_ALE, 32'h1c000105, 0, 0, 0, 0, 0,
                  14'h007, 1, 32'h1c000000, 32'h1c000105);
      tv[1]  = idl(14'h006, 1, 32'h1c000000, 32'h1c000010);
      tv[2]  = idl(14'h005, 0, 32'h1c000000, 32'h00090000);
      tv[3]  = mk(1, 32'h1c000022, F_ADEF | F_ALE, 32'h1c000999, 0, 0, 0, 0, 0,
                  14'h005, 1, 32'h1c000000, 32'h00080000);
      tv[4]  = idl(14'h007, 1, 32'h1c000000, 32'h1c000022);
      tv[5]  = idl(14'h006, 0, 32'h1c000000, 32'h1c000022);
      tv[6]  = mk(1, 32'h1c000030, 0, 0, 0, 14'h007, 1, 32'hffffffff, 32'h5a,
                  14'h007, 0, 32'h1c000000, 32'h5a);
      tv[7]  = mk(1, 32'h1c000034, 0, 0, 0, 14'h007, 1, 32'hf0, 32'ha5,
                  14'h007, 0, 32'h1c000000, 32'haa);
      tv[8]  = mk(1, 32'h1c000038, 0, 0, 0, 14'h00c, 1, 32'hffffffff,
                  32'h1c0000ff, 14'h00c, 0, 32'h1c000000, 32'h1c0000c0);
      tv[9]  = mk(1, 32'h1c000040, F_SYS, 0, 0, 0, 0, 0, 0,
                  14'h005, 1, 32'h1c0000c0, 32'h000b0000);
      tv[10] = mk(1, 32'h1c000abc, F_BRK | F_ALE, 32'h77, 0, 14'h007, 1,
                  32'hffffffff, 32'h123, 14'h007, 1, 32'h1c0000c0, 32'haa);
      tv[11] = idl(14'h006, 0, 32'h1c0000c0, 32'h1c000040);
      tv[12] = mk(1, 32'h1c000050, 0, 0, 1, 0, 0, 0, 0,
                  14'h006, 1, 32'h1c000040, 32'h1c000040);
      tv[13] = idl(14'h005, 1, 32'h1c000040, 32'h000b0000);
      tv[14] = idl(14'h005, 0, 32'h1c000040, 32'h000b0000);
      tv[15] = mk(1, 32'h1c000080, F_INE, 0, 0, 14'h006, 1, 32'h0000ffff,
                  32'hdeadbeef, 14'h006, 1, 32'h1c0000c0, 32'h1c000080);
      tv[16] = idl(14'h005, 1, 32'h1c0000c0, 32'h000d0000);
      tv[17] = idl(14'h100, 0, 32'h1c0000c0, 32'h0);
      tv[18] = mk(1, 32'h1c000090, 0, 0, 0, 14'h005, 1, 32'hffffffff,
                  32'hffffffff, 14'h005, 0, 32'h1c0000c0, 32'h000d0003);
      tv[19] = mk(1, 32'h1c000094, 0, 0, 0, 14'h006, 1, 32'hffffffff,
                  32'h1c001000, 14'h006, 0, 32'h1c0000c0, 32'h1c001000);
      tv[20] = mk(1, 32'h1c000098, 0, 0, 1, 0, 0, 0, 0,
                  14'h007, 1, 32'h1c001000, 32'haa);
      tv[21] = idl(14'h006, 1, 32'h1c001000, 32'h1c001000);
      tv[22] = idl(14'h006, 0, 32'h1c001000, 32'h1c001000);
      tv[23] = mk(1, 32'h1c000200, F_BRK, 0, 0, 0, 0, 0, 0,
                  14'h005, 1, 32'h1c0000c0, 32'h000c0003);
      tv[24] = idl(14'h007, 1, 32'h1c0000c0, 32'haa);
      tv[25] = idl(14'h007, 0, 32'h1c0000c0, 32'haa);
      tv[26] = mk(1, 32'h1c000210, 0, 0, 0, 14'h0f0, 1, 32'hffffffff,
                  32'h1234, 14'h0f0, 0, 32'h1c0000c0, cnt_exp);

      resetn = 1'b0;
      quiet(14'h0);
      #1;
      chk("async_reset_flush", {31'b0, excp_flush}, 32'h0);
      do_reset();
      #1;
      chk("reset_flush", {31'b0, excp_flush}, 32'h0);
      chk("reset_target", excp_target, 32'h0);
      foreach (nums[i]) begin
         csr_num = nums[i];
         #1;
         chk($sformatf("reset_rd_%0h", nums[i]), csr_rdata,
             (nums[i] == 14'h00c) ? 32'h1c000000 : 32'h0);
      end

      for (int i = 0; i < NV; i++) begin
         cyc(tv[i]);
         #1;
         chk($sformatf("vec%0d_flush", i), {31'b0, excp_flush}, {31'b0, tv[i].e_fl});
         chk($sformatf("vec%0d_target", i), excp_target, tv[i].e_tgt);
         chk($sformatf("vec%0d_rd", i), csr_rdata, tv[i].e_rd);
      end

      // reset asserted in the middle of a flush window
      cyc(mk(1, 32'h1c000300, F_SYS, 0, 0, 0, 0, 0, 0, 14'h006, 1, 0, 0));
      #1;
      chk("midflush_pre", {31'b0, excp_flush}, 32'h1);
      resetn = 1'b0;
      #1;
      chk("midflush_flush", {31'b0, excp_flush}, 32'h0);
      chk("midflush_target", excp_target, 32'h0);
      chk("midflush_era", csr_rdata, 32'h0);
      csr_num = 14'h00c;
      #1;
      chk("midflush_eentry", csr_rdata, 32'h1c000000);
      @(negedge clk);
      resetn = 1'b1;

`ifdef CSR_EXCP_CNT_EN
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cyc(mk(1, 32'h1c000400 + k * 4, F_INE, 0, 0, 0, 0, 0, 0,
                14'h0f0, 1, 0, 0));
         repeat (3) cyc(idl(14'h0f0, 0, 0, 0));
      end
      #1;
      chk("cnt_three", csr_rdata, 32'd3);
      cyc(mk(1, 32'h1c000500, 0, 0, 0, 14'h0f0, 1, 32'hffffffff,
             32'hffffffff, 14'h0f0, 0, 0, 0));
      #1;
      chk("cnt_preload", csr_rdata, 32'hffffffff);
      cyc(mk(1, 32'h1c000504, F_ALE, 32'h3, 0, 0, 0, 0, 0, 14'h0f0, 1, 0, 0));
      #1;
      chk("cnt_wrap", csr_rdata, 32'h0);
`endif

      // randomized run against the reference model
      do_reset();
      m_reset();
      for (int c = 0; c < 800; c++) begin
         vec_t r;
         logic [4:0] f;
         f = 0;
         for (int b = 0; b < 5; b++) f[b] = ($urandom_range(0, 9) == 0);
         r = mk($urandom_range(0, 3) != 0, $urandom, f, $urandom,
                $urandom_range(0, 7) == 0,
                ($urandom_range(0, 7) == 0) ? 14'($urandom)
                                            : nums[$urandom_range(0, 5)],
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) ? 32'hffffffff : $urandom,
                $urandom, 0, 0, 0, 0);
         @(negedge clk);
         drive(r);
         #1;
         chk("rand_flush", {31'b0, excp_flush}, {31'b0, m_fl > 0});
         chk("rand_target", excp_target, m_tgt);
         chk("rand_rdata", csr_rdata, m_rd(r.num));
         @(posedge clk);
         m_step(r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
